// File: rtl/dbg_reg_scanner.sv
// Debug register scanner: walks the register-file debug port and captures one
// selected source per step into a registered display latch.
// Optional build macro SCAN_SKIP_X0_EN: when defined, x0 is never scanned
// (index resets to 1 and wraps 31 -> 1).
module dbg_reg_scanner #(
    parameter int unsigned DWELL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    input  logic        step,
    input  logic [1:0]  disp_sel,
    input  logic [31:0] reg_data,
    input  logic [31:0] pc_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    output logic [4:0]  reg_sel,
    output logic [31:0] disp_data,
    output logic [4:0]  disp_idx,
    output logic        disp_valid
);

    localparam int unsigned IDX_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

`ifdef SCAN_SKIP_X0_EN
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
`else
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(0);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_inc;
    logic [CNT_W-1:0]    dwell_cnt;
    logic                step_q;
    logic                step_rise;
    logic [DATA_W-1:0]   mux_data;

    assign reg_sel   = idx;
    assign step_rise = step & ~step_q;

    // Next scan index; the top register wraps back to the first scanned one.
    always_comb begin
        idx_inc = idx + IDX_W'(1);
        if (idx == IDX_W'(31)) begin
            idx_inc = IDX_FIRST;
        end
    end

    // Display source select.
    always_comb begin
        mux_data = reg_data;
        case (disp_sel)
            2'd0: mux_data = reg_data;
            2'd1: mux_data = pc_in;
            2'd2: mux_data = addr_in;
            2'd3: mux_data = data_in;
            default: mux_data = reg_data;
        endcase
    end

    // Scan FSM with step edge detect, dwell timing and display capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= IDX_FIRST;
            dwell_cnt  <= '0;
            step_q     <= 1'b0;
            disp_data  <= '0;
            disp_idx   <= '0;
            disp_valid <= 1'b0;
        end else begin
            step_q     <= step;
            disp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_en) begin
                        state <= SETTLE;
                    end else if (step_rise) begin
                        idx   <= idx_inc;
                        state <= SETTLE;
                    end
                end
                // One full cycle for reg_data to follow the new reg_sel.
                SETTLE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    disp_data  <= mux_data;
                    disp_idx   <= idx;
                    disp_valid <= 1'b1;
                    dwell_cnt  <= '0;
                    state      <= HOLD;
                end
                HOLD: begin
                    disp_data <= mux_data;
                    if (!scan_en) begin
                        dwell_cnt <= '0;
                        state     <= IDLE;
                    end else if (dwell_cnt == CNT_LAST) begin
                        idx   <= idx_inc;
                        state <= SETTLE;
                    end else begin
                        dwell_cnt <= dwell_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_reg_scanner.sv
// Bench for dbg_reg_scanner: directed scenarios with literal expectations plus
// a randomized run checked every cycle against a behavioural model.
module tb_dbg_reg_scanner;

    localparam int unsigned DWELL = 4;

`ifdef SCAN_SKIP_X0_EN
    localparam logic [4:0] RST_IDX = 5'd1;
`else
    localparam logic [4:0] RST_IDX = 5'd0;
`endif

    logic        clk;
    logic        rst;
    logic        scan_en;
    logic        step;
    logic [1:0]  disp_sel;
    logic [31:0] reg_data;
    logic [31:0] pc_in;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [4:0]  reg_sel;
    logic [31:0] disp_data;
    logic [4:0]  disp_idx;
    logic        disp_valid;
    logic [31:0] rd_base;

    int checks = 0;
    int errors = 0;

    dbg_reg_scanner #(.DWELL_CYCLES(DWELL)) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_en    (scan_en),
        .step       (step),
        .disp_sel   (disp_sel),
        .reg_data   (reg_data),
        .pc_in      (pc_in),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .reg_sel    (reg_sel),
        .disp_data  (disp_data),
        .disp_idx   (disp_idx),
        .disp_valid (disp_valid)
    );

    // Register-file read data follows reg_sel combinationally.
    assign reg_data = rd_base + 32'(reg_sel);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [4:0] nxt(input logic [4:0] i);
`ifdef SCAN_SKIP_X0_EN
        return (i == 5'd31) ? 5'd1 : 5'(int'(i) + 1);
`else
        return 5'((int'(i) + 1) % 32);
`endif
    endfunction

    // ---------------- behavioural model ----------------
    // busy: a capture sequence is in progress; phase counts cycles since
    // leaving idle (0 settle, 1 capture, 2..DWELL+1 hold).
    logic [4:0]  m_idx;
    logic [31:0] m_data;
    logic [4:0]  m_didx;
    logic        m_valid;
    bit          m_busy;
    bit          m_stepq;
    bit          m_ok = 1'b0;
    int          m_phase;

    function automatic logic [31:0] source(input logic [1:0] sel, input logic [4:0] i);
        case (sel)
            2'd1:    return pc_in;
            2'd2:    return addr_in;
            2'd3:    return data_in;
            default: return rd_base + 32'(i);
        endcase
    endfunction

    initial begin
        logic [31:0] src;
        bit rise;
        forever begin
            @(posedge clk);
            src = source(disp_sel, m_idx);
            if (rst) begin
                m_ok = 1'b1; m_busy = 1'b0; m_phase = 0; m_stepq = 1'b0;
                m_idx = RST_IDX; m_data = '0; m_didx = '0; m_valid = 1'b0;
            end else begin
                rise    = step && !m_stepq;
                m_stepq = step;
                m_valid = 1'b0;
                if (!m_busy) begin
                    if (scan_en) begin
                        m_busy = 1'b1; m_phase = 0;
                    end else if (rise) begin
                        m_busy = 1'b1; m_phase = 0; m_idx = nxt(m_idx);
                    end
                end else if (m_phase == 0) begin
                    m_phase = 1;
                end else if (m_phase == 1) begin
                    m_data = src; m_didx = m_idx; m_valid = 1'b1; m_phase = 2;
                end else begin
                    m_data = src;
                    if (!scan_en) begin
                        m_busy = 1'b0;
                    end else if (m_phase == int'(DWELL) + 1) begin
                        m_idx = nxt(m_idx); m_phase = 0;
                    end else begin
                        m_phase++;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) begin
                chk("cmp_reg_sel",    32'(reg_sel),    32'(m_idx));
                chk("cmp_disp_data",  disp_data,       m_data);
                chk("cmp_disp_idx",   32'(disp_idx),   32'(m_didx));
                chk("cmp_disp_valid", 32'(disp_valid), 32'(m_valid));
            end
        end
    end

    // Hard time limit.
    initial begin
        #400000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    task automatic rand_inputs();
        scan_en  = 1'($urandom);
        step     = 1'($urandom);
        disp_sel = 2'($urandom);
        pc_in    = $urandom;
        addr_in  = $urandom;
        data_in  = $urandom;
        rd_base  = $urandom;
    endtask

    // Two reset cycles with random inputs; returns at a negedge, reset released.
    task automatic reset_dut();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            @(negedge clk);
        end
        rst = 1'b0; scan_en = 1'b0; step = 1'b0; disp_sel = 2'd0;
        rd_base = 32'h1000_0000;
    endtask

    initial begin
        int k;
        int cyc;
        int last;
        int pulses;
        logic [4:0] exp_idx;
        logic [4:0] got_idx;
        bit found;

        // Reset state.
        reset_dut();
        chk("rst_reg_sel",    32'(reg_sel),    32'(RST_IDX));
        chk("rst_disp_data",  disp_data,       32'h0);
        chk("rst_disp_idx",   32'(disp_idx),   32'h0);
        chk("rst_disp_valid", 32'(disp_valid), 32'h0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (disp_valid) pulses++;
        end
        chk("rst_idle_no_pulse", 32'(pulses), 32'd0);
        chk("rst_idle_reg_sel",  32'(reg_sel), 32'(RST_IDX));

        // Auto scan through the wrap.
        reset_dut();
        scan_en = 1'b1;
        k = 0; cyc = 0; last = 0; exp_idx = RST_IDX;
        while (k < 33 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (disp_valid) begin
                if (k == 0) chk("auto_first_latency", 32'(cyc), 32'd3);
                else        chk("auto_period", 32'(cyc - last), 32'(DWELL + 2));
                chk("auto_idx",  32'(disp_idx), 32'(exp_idx));
                chk("auto_data", disp_data, 32'h1000_0000 + 32'(exp_idx));
                last = cyc;
                exp_idx = nxt(exp_idx);
                k++;
            end
        end
        chk("auto_pulse_count", 32'(k), 32'd33);

        // Source switch while holding.
        reset_dut();
        scan_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (disp_valid) found = 1'b1;
        end
        chk("src_capture_seen", 32'(found), 32'd1);
        disp_sel = 2'd1;
        pc_in    = 32'h0000_0040;
        @(negedge clk);
        chk("src_disp_data",  disp_data,       32'h0000_0040);
        chk("src_disp_valid", 32'(disp_valid), 32'd0);
        @(negedge clk);
        chk("src_disp_valid2", 32'(disp_valid), 32'd0);

        // Scan stop at index 5.
        reset_dut();
        scan_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (disp_valid && disp_idx == 5'd5) found = 1'b1;
        end
        chk("stop_idx5_seen", 32'(found), 32'd1);
        scan_en = 1'b0;
        @(negedge clk);
        chk("stop_reg_sel", 32'(reg_sel), 32'd5);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (disp_valid) pulses++;
        end
        chk("stop_no_pulse",     32'(pulses),  32'd0);
        chk("stop_reg_sel_hold", 32'(reg_sel), 32'd5);

        // Manual step held high: exactly one advance.
        reset_dut();
        step = 1'b1;
        pulses = 0; got_idx = '0;
        for (int i = 0; i < 15; i++) begin
            if (i == 10) step = 1'b0;
            @(negedge clk);
            if (disp_valid) begin
                pulses++;
                got_idx = disp_idx;
            end
        end
        chk("step_pulses",  32'(pulses),  32'd1);
        chk("step_idx",     32'(got_idx), 32'(RST_IDX) + 32'd1);
        chk("step_reg_sel", 32'(reg_sel), 32'(RST_IDX) + 32'd1);

        // Reset asserted in CAPTURE.
        reset_dut();
        scan_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rcap_reg_sel",    32'(reg_sel),    32'(RST_IDX));
        chk("rcap_disp_data",  disp_data,       32'h0);
        chk("rcap_disp_idx",   32'(disp_idx),   32'h0);
        chk("rcap_disp_valid", 32'(disp_valid), 32'h0);
        rst = 1'b0; scan_en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (disp_valid) pulses++;
        end
        chk("rcap_no_pulse", 32'(pulses), 32'd0);

        // Randomized run, checked by the model every cycle.
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(199) == 0);
            if ($urandom_range(29) == 0) scan_en = ~scan_en;
            if ($urandom_range(5) == 0)  step = ~step;
            if ($urandom_range(7) == 0)  disp_sel = 2'($urandom);
            if ($urandom_range(49) == 0) rd_base = $urandom;
            pc_in   = $urandom;
            addr_in = $urandom;
            data_in = $urandom;
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
